// File: rtl/cache_line_writeback_if.sv
// Write-back word stream from the cache to the next memory level.
// The master drives one word per valid/ready handshake.
interface cache_line_writeback_if #(
    parameter int CW = 3,
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [CW-1:0] idx;
    logic          last;

    modport master (
        output valid, data, idx, last,
        input  ready
    );

    modport slave (
        input  valid, data, idx, last,
        output ready
    );
endinterface

// File: rtl/cache_line_writeback.sv
// Reads one cache line out of the data RAM in fill order
// and streams it word by word to the memory-side port.
module cache_line_writeback #(
    parameter int WORDS = 8,
    parameter int CW    = 3,
    parameter int AW    = 11,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-CW-1:0]    line_base,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_rd,
    input  logic [DW-1:0]       ram_dout,
    cache_line_writeback_if.master wb,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t           state;
    logic [AW-CW-1:0] base;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    data;
    logic             valid;
    logic             last;

    assign wb.valid = valid;
    assign wb.data  = data;
    assign wb.idx   = cnt;
    assign wb.last  = last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            cnt      <= '0;
            data     <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            ram_addr <= '0;
            ram_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base     <= line_base;
                        cnt      <= '0;
                        ram_addr <= {line_base, {CW{1'b0}}};
                        ram_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // RAM data is valid one cycle after the read strobe
                    data  <= ram_dout;
                    valid <= 1'b1;
                    last  <= (cnt == LAST);
                    state <= SEND;
                end
                SEND: begin
                    if (wb.ready) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        if (cnt == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            ram_addr <= {base, cnt + 1'b1};
                            ram_rd   <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_line_writeback.sv
// Bench for cache_line_writeback: RAM model, scoreboard of
// expected addresses and words, table of line runs plus corner cases.
module tb_cache_line_writeback;
    localparam int WORDS = 8;
    localparam int CW    = 3;
    localparam int AW    = 11;
    localparam int DW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-CW-1:0] line_base;
    logic [AW-1:0]    ram_addr;
    logic             ram_rd;
    logic [DW-1:0]    ram_dout;
    logic             busy;
    logic             done;

    cache_line_writeback_if #(.CW(CW), .DW(DW)) wbi ();

    cache_line_writeback #(
        .WORDS(WORDS), .CW(CW), .AW(AW), .DW(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .line_base (line_base),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_dout  (ram_dout),
        .wb        (wbi),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] i;
        logic          l;
    } word_t;

    typedef struct {
        logic [7:0] base;
        int         sidx;
        int         slen;
        int         exp_busy;
        int         exp_rd;
        int         exp_done;
    } vec_t;

    logic [DW-1:0] mem [0:2**AW-1];
    word_t         exp_q[$];
    logic [AW-1:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc, rd_cnt, busy_cnt, done_cnt;
    int first_rd, first_valid;
    int stall_idx, stall_left;
    logic  pv, pr;
    word_t pw;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a[AW-1:CW] == 8'h05) return 8'h10 + DW'(a[CW-1:0]);
        return {a[6:3], 1'b1, a[2:0]};
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // RAM: data one cycle after the strobe, noise otherwise
    always @(posedge clk) begin
        if (ram_rd === 1'b1) ram_dout <= mem[ram_addr];
        else ram_dout <= DW'($urandom);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        word_t cur;
        cur = {wbi.data, wbi.idx, wbi.last};
        if (ram_rd === 1'b1) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc - start_cyc;
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: addr %h, no read expected",
                         ram_addr);
            end else chk("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (wbi.valid === 1'b1) begin
            if (first_valid < 0) first_valid = cyc - start_cyc;
            if (pv && !pr) chk("hold", 32'(cur), 32'(pw));
            if (wbi.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h, none expected",
                             cur);
                end else chk("word", 32'(cur), 32'(exp_q.pop_front()));
            end
        end
        pv = (wbi.valid === 1'b1);
        pr = wbi.ready;
        pw = cur;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (wbi.valid && stall_left > 0 && wbi.idx == CW'(stall_idx)) begin
            wbi.ready = 1'b0;
            stall_left--;
        end else if (!wbi.valid) begin
            wbi.ready = 1'($urandom);
        end else begin
            wbi.ready = 1'b1;
        end
    endtask

    task automatic line(input logic [7:0] b, input int sidx,
                        input int slen, input int inj_idx,
                        input bit inj_done, input int rst_idx,
                        input int tail);
        bit injd;
        int n;
        injd = 0;
        n = 0;
        rd_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        first_rd = -1;
        first_valid = -1;
        stall_idx = sidx;
        stall_left = slen;
        for (int i = 0; i < WORDS; i++) begin
            addr_q.push_back({b, CW'(i)});
            exp_q.push_back({pat({b, CW'(i)}), CW'(i), i == WORDS - 1});
        end
        start_cyc = cyc;
        start = 1'b1;
        line_base = b;
        cycle();
        start = 1'b0;
        line_base = 8'($urandom);
        while (1) begin
            if (rst_idx >= 0 && wbi.valid && wbi.idx == CW'(rst_idx)) begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
                chk("rst_valid", 32'(wbi.valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_left", exp_q.size(), WORDS - rst_idx);
                exp_q.delete();
                addr_q.delete();
                repeat (3) cycle();
                chk("rst_done", done_cnt, 0);
                return;
            end
            if (inj_idx >= 0 && !injd && wbi.valid &&
                wbi.idx == CW'(inj_idx)) begin
                start = 1'b1;
                line_base = 8'h09;
                injd = 1;
            end else if (inj_done && done) begin
                start = 1'b1;
                line_base = 8'h09;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0 && !busy) break;
            if (++n > 400) begin
                checks++;
                errors++;
                $display("FAIL line_timeout: base %h no done", b);
                break;
            end
            cycle();
        end
        start = 1'b0;
        repeat (tail) cycle();
    endtask

    task automatic line_checks(input int eb, input int er, input int ed);
        chk("busy_cycles", busy_cnt, eb);
        chk("rd_count", rd_cnt, er);
        chk("done_count", done_cnt, ed);
        chk("words_left", exp_q.size(), 0);
        chk("rd_latency", first_rd, 1);
        chk("valid_latency", first_valid, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{8'h05, 0, 0, 25, 8, 1};
        vecs[1] = '{8'h05, 3, 4, 29, 8, 1};
        vecs[2] = '{8'h06, 7, 2, 27, 8, 1};
        vecs[3] = '{8'hFF, 0, 3, 28, 8, 1};
        vecs[4] = '{8'h00, 5, 1, 26, 8, 1};

        for (int a = 0; a < 2**AW; a++) mem[a] = pat(AW'(a));
        reset = 1'b1;
        start = 1'b0;
        line_base = '0;
        wbi.ready = 1'b0;
        stall_idx = 0;
        stall_left = 0;
        start_cyc = 0;
        first_rd = -1;
        first_valid = -1;
        pv = 1'b0;
        pr = 1'b0;
        pw = '0;
        repeat (3) cycle();
        chk("reset_outputs", 32'({ram_addr, ram_rd, wbi.valid, wbi.data,
                                  wbi.idx, wbi.last, busy, done}), 0);
        reset = 1'b0;
        cycle();

        for (int v = 0; v < 5; v++) begin
            line(vecs[v].base, vecs[v].sidx, vecs[v].slen, -1, 0, -1, 3);
            line_checks(vecs[v].exp_busy, vecs[v].exp_rd, vecs[v].exp_done);
        end

        // start during SEND of word 2 and during DONE must be ignored
        line(8'h05, 0, 0, 2, 1, -1, 6);
        line_checks(25, 8, 1);

        // reset while word 5 waits, then a clean line from word 0
        line(8'h05, 5, 100, -1, 0, 5, 0);
        line(8'h05, 0, 0, -1, 0, -1, 3);
        line_checks(25, 8, 1);

        // back-to-back lines, second start the cycle after done
        line(8'h05, 0, 0, -1, 0, -1, 0);
        line_checks(25, 8, 1);
        line(8'h06, 0, 0, -1, 0, -1, 3);
        line_checks(25, 8, 1);

        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        line_base = 8'h33;
        cycle();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_outputs", 32'({ram_addr, ram_rd, wbi.valid, wbi.data,
                                      wbi.idx, wbi.last, busy, done}), 0);
        rd_cnt = 0;
        busy_cnt = 0;
        repeat (4) cycle();
        chk("rst_start_rd", rd_cnt, 0);
        chk("rst_start_busy", busy_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
